// File: rtl/control_unit_hs.sv
// control_unit_hs: multi-cycle sequencer for the accumulator CPU with memory handshake,
// timeout fault, separate DECODE cycle and scannable state. Optional macro: SINGLE_STEP_EN.
module control_unit_hs #(
    parameter logic [7:0]  HALT_OPCODE = 8'hFF,
    parameter int unsigned TIMEOUT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       processor_enable,
    input  logic [7:0] instruction,
    input  logic       ZF,
    input  logic       mem_ack,
    input  logic       scan_enable,
    input  logic       scan_in,
`ifdef SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step_go,
`endif
    output logic       scan_out,
    output logic       processor_halted,
    output logic       fault,
    output logic       mem_req,
    output logic       IR_load_enable,
    output logic       PC_write_enable,
    output logic [1:0] PC_mux_select,
    output logic       ACC_write_enable,
    output logic [1:0] ACC_mux_select,
    output logic [3:0] ALU_opcode,
    output logic       ALU_inputB_mux_select,
    output logic       Memory_write_enable,
    output logic [1:0] Memory_address_mux_select
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_next;
    logic                 fault_set;
    logic                 run;
    logic                 fetch_go;
    logic                 cnt_full;

    logic is_lda;
    logic is_sta;
    logic is_memalu;
    logic is_ldar;
    logic is_addi;
    logic is_acc_op;

    assign run              = processor_enable && !scan_enable;
    assign cnt_full         = &cnt;
    assign scan_out         = state[2];
    assign processor_halted = (state == S_HALT);

    assign is_lda    = (instruction[7:5] == 3'b000);
    assign is_sta    = (instruction[7:5] == 3'b001);
    assign is_memalu = (instruction[7:5] inside {[3'd2:3'd6]});
    assign is_ldar   = (instruction == 8'hFB);
    assign is_addi   = (instruction[7:4] == 4'hE);
    assign is_acc_op = (instruction inside {[8'hF6:8'hFA], [8'hFC:8'hFE]});

`ifdef SINGLE_STEP_EN
    // A step_go pulse grants exactly one fetch; the grant persists while the access waits.
    logic step_granted;

    assign fetch_go = !step_mode || step_go || step_granted;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_granted <= 1'b0;
        end else if (run) begin
            step_granted <= (state == S_FETCH) && (next_state == S_FETCH) && fetch_go;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            cnt   <= '0;
            fault <= 1'b0;
        end else if (scan_enable) begin
            state <= state_t'({state[1:0], scan_in});
        end else if (processor_enable) begin
            state <= next_state;
            cnt   <= cnt_next;
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    // Counter restarts from zero in every state that is not an ongoing memory wait.
    always_comb begin
        next_state                = state;
        cnt_next                  = '0;
        fault_set                 = 1'b0;
        mem_req                   = 1'b0;
        IR_load_enable            = 1'b0;
        PC_write_enable           = 1'b0;
        PC_mux_select             = 2'b00;
        ACC_write_enable          = 1'b0;
        ACC_mux_select            = 2'b00;
        ALU_inputB_mux_select     = 1'b0;
        Memory_write_enable       = 1'b0;
        Memory_address_mux_select = 2'b00;
        if (run) begin
            case (state)
                S_RESET: begin
                    next_state = S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_go) begin
                        mem_req                   = 1'b1;
                        Memory_address_mux_select = 2'b10;
                        if (mem_ack) begin
                            IR_load_enable  = 1'b1;
                            PC_write_enable = 1'b1;
                            next_state      = S_DECODE;
                        end else if (cnt_full) begin
                            next_state = S_HALT;
                            fault_set  = 1'b1;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt;
                    end
                end
                S_DECODE: begin
                    if (instruction == HALT_OPCODE) begin
                        next_state = S_HALT;
                    end else if (is_lda || is_sta || is_memalu || is_ldar) begin
                        next_state = S_MEM;
                    end else begin
                        next_state = S_EXEC;
                    end
                end
                S_MEM: begin
                    mem_req                   = 1'b1;
                    Memory_address_mux_select = is_ldar ? 2'b01 : 2'b00;
                    Memory_write_enable       = is_sta;
                    if (mem_ack) begin
                        if (is_lda || is_ldar) begin
                            ACC_write_enable = 1'b1;
                            ACC_mux_select   = 2'b01;
                        end else if (is_memalu) begin
                            ACC_write_enable = 1'b1;
                        end
                        next_state = S_FETCH;
                    end else if (cnt_full) begin
                        next_state = S_HALT;
                        fault_set  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    next_state = S_FETCH;
                    if (is_addi) begin
                        ACC_write_enable      = 1'b1;
                        ALU_inputB_mux_select = 1'b1;
                    end else begin
                        case (instruction)
                            8'hF0: begin
                                PC_write_enable = 1'b1;
                                PC_mux_select   = 2'b01;
                            end
                            8'hF1: begin
                                PC_write_enable  = 1'b1;
                                PC_mux_select    = 2'b01;
                                ACC_write_enable = 1'b1;
                                ACC_mux_select   = 2'b10;
                            end
                            8'hF2: begin
                                PC_write_enable = ZF;
                                PC_mux_select   = ZF ? 2'b11 : 2'b00;
                            end
                            8'hF3: begin
                                PC_write_enable = ZF;
                                PC_mux_select   = ZF ? 2'b10 : 2'b00;
                            end
                            8'hF4: begin
                                PC_write_enable = !ZF;
                                PC_mux_select   = !ZF ? 2'b11 : 2'b00;
                            end
                            8'hF5: begin
                                PC_write_enable = !ZF;
                                PC_mux_select   = !ZF ? 2'b10 : 2'b00;
                            end
                            default: begin
                                ACC_write_enable = is_acc_op;
                            end
                        endcase
                    end
                end
                S_HALT: begin
                    next_state = S_HALT;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    // ALU operation follows the IR in every state except RESET, where all outputs rest at zero.
    always_comb begin
        ALU_opcode = 4'b0000;
        if (state != S_RESET) begin
            case (instruction[7:5])
                3'b010:  ALU_opcode = 4'b0000;
                3'b011:  ALU_opcode = 4'b0001;
                3'b100:  ALU_opcode = 4'b0010;
                3'b101:  ALU_opcode = 4'b0011;
                3'b110:  ALU_opcode = 4'b0100;
                3'b111: begin
                    case (instruction)
                        8'hF6:   ALU_opcode = 4'b0101;
                        8'hF7:   ALU_opcode = 4'b0110;
                        8'hF8:   ALU_opcode = 4'b0111;
                        8'hF9:   ALU_opcode = 4'b1000;
                        8'hFA:   ALU_opcode = 4'b1001;
                        8'hFC:   ALU_opcode = 4'b1010;
                        8'hFE:   ALU_opcode = 4'b1011;
                        8'hFD:   ALU_opcode = 4'b1100;
                        default: ALU_opcode = 4'b0000;
                    endcase
                end
                default: ALU_opcode = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_hs.sv
// Scoreboard bench for control_unit_hs: instruction-level reference model pushes expected
// per-cycle control vectors; a negedge monitor pops and compares them.
module tb_control_unit_hs;

    typedef struct packed {
        logic       mem_req;
        logic       ir_le;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       acc_we;
        logic [1:0] acc_sel;
        logic [3:0] alu;
        logic       inb;
        logic       mem_we;
        logic [1:0] addr;
        logic       halted;
        logic       fault;
        logic       sout;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       processor_enable;
    logic [7:0] instruction;
    logic       ZF;
    logic       mem_ack;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       processor_halted;
    logic       fault;
    logic       mem_req;
    logic       IR_load_enable;
    logic       PC_write_enable;
    logic [1:0] PC_mux_select;
    logic       ACC_write_enable;
    logic [1:0] ACC_mux_select;
    logic [3:0] ALU_opcode;
    logic       ALU_inputB_mux_select;
    logic       Memory_write_enable;
    logic [1:0] Memory_address_mux_select;

    outs_t exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  fault_now = 1'b0;
    logic  in_halt   = 1'b0;

    control_unit_hs dut (
        .clk                      (clk),
        .rst                      (rst),
        .processor_enable         (processor_enable),
        .instruction              (instruction),
        .ZF                       (ZF),
        .mem_ack                  (mem_ack),
        .scan_enable              (scan_enable),
        .scan_in                  (scan_in),
        .scan_out                 (scan_out),
        .processor_halted         (processor_halted),
        .fault                    (fault),
        .mem_req                  (mem_req),
        .IR_load_enable           (IR_load_enable),
        .PC_write_enable          (PC_write_enable),
        .PC_mux_select            (PC_mux_select),
        .ACC_write_enable         (ACC_write_enable),
        .ACC_mux_select           (ACC_mux_select),
        .ALU_opcode               (ALU_opcode),
        .ALU_inputB_mux_select    (ALU_inputB_mux_select),
        .Memory_write_enable      (Memory_write_enable),
        .Memory_address_mux_select(Memory_address_mux_select)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        outs_t e;
        outs_t a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {mem_req, IR_load_enable, PC_write_enable, PC_mux_select, ACC_write_enable,
                 ACC_mux_select, ALU_opcode, ALU_inputB_mux_select, Memory_write_enable,
                 Memory_address_mux_select, processor_halted, fault, scan_out};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] alu_ref(input logic [7:0] ir);
        if (ir[7:5] >= 3'd2 && ir[7:5] <= 3'd6) return {1'b0, ir[7:5] - 3'd2};
        if (ir >= 8'hF6 && ir <= 8'hFA) return 4'(ir - 8'hF1);
        if (ir == 8'hFC) return 4'd10;
        if (ir == 8'hFE) return 4'd11;
        if (ir == 8'hFD) return 4'd12;
        return 4'd0;
    endfunction

    // Quiet outputs for a given architectural state number.
    function automatic outs_t idle_vec(input logic [7:0] ir, input logic [2:0] st);
        outs_t v = '0;
        v.alu    = (st == 3'd0) ? 4'd0 : alu_ref(ir);
        v.halted = (st == 3'd5);
        v.fault  = fault_now;
        v.sout   = st[2];
        return v;
    endfunction

    function automatic outs_t fetch_vec(input logic ack);
        outs_t v = idle_vec(instruction, 3'd1);
        v.mem_req = 1'b1;
        v.addr    = 2'b10;
        if (ack) begin
            v.ir_le = 1'b1;
            v.pc_we = 1'b1;
        end
        return v;
    endfunction

    function automatic outs_t mem_vec(input logic [7:0] ir, input logic ack);
        outs_t v = idle_vec(ir, 3'd3);
        v.mem_req = 1'b1;
        v.addr    = (ir == 8'hFB) ? 2'b01 : 2'b00;
        v.mem_we  = (ir[7:5] == 3'b001);
        if (ack) begin
            if (ir[7:5] == 3'b000 || ir == 8'hFB) begin
                v.acc_we  = 1'b1;
                v.acc_sel = 2'b01;
            end else if (ir[7:5] != 3'b001) begin
                v.acc_we = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic outs_t exec_vec(input logic [7:0] ir, input logic zf);
        outs_t v = idle_vec(ir, 3'd4);
        if (ir[7:4] == 4'hE) begin
            v.acc_we = 1'b1;
            v.inb    = 1'b1;
        end else if (ir == 8'hF0) begin
            v.pc_we  = 1'b1;
            v.pc_sel = 2'b01;
        end else if (ir == 8'hF1) begin
            v.pc_we   = 1'b1;
            v.pc_sel  = 2'b01;
            v.acc_we  = 1'b1;
            v.acc_sel = 2'b10;
        end else if ((ir == 8'hF2 && zf) || (ir == 8'hF4 && !zf)) begin
            v.pc_we  = 1'b1;
            v.pc_sel = 2'b11;
        end else if ((ir == 8'hF3 && zf) || (ir == 8'hF5 && !zf)) begin
            v.pc_we  = 1'b1;
            v.pc_sel = 2'b10;
        end else if (ir >= 8'hF6 && ir <= 8'hFE && ir != 8'hFB) begin
            v.acc_we = 1'b1;
        end
        return v;
    endfunction

    task automatic push(input string n, input outs_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enters with the DUT in FETCH; fw/mw are wait cycles before mem_ack (>15 means never).
    task automatic run_instr(input logic [7:0] ir, input logic zf, input int fw, input int mw);
        int last;
        ZF   = zf;
        last = (fw > 15) ? 15 : fw;
        for (int k = 0; k <= last; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                processor_enable = 1'b0;
                mem_ack          = 1'b0;
                push("freeze", idle_vec(instruction, 3'd1));
                step();
                processor_enable = 1'b1;
            end
            mem_ack = (k == fw);
            if (k == fw) push("fetch_ack", fetch_vec(1'b1));
            else push("fetch_wait", fetch_vec(1'b0));
            step();
        end
        if (fw > 15) begin
            fault_now = 1'b1;
            in_halt   = 1'b1;
            return;
        end
        instruction = ir;
        mem_ack     = 1'($urandom_range(0, 1));
        push("decode", idle_vec(ir, 3'd2));
        step();
        if (ir == 8'hFF) begin
            in_halt = 1'b1;
            return;
        end
        if (ir[7:5] != 3'b111 || ir == 8'hFB) begin
            last = (mw > 15) ? 15 : mw;
            for (int k = 0; k <= last; k++) begin
                mem_ack = (k == mw);
                if (k == mw) push("mem_ack", mem_vec(ir, 1'b1));
                else push("mem_wait", mem_vec(ir, 1'b0));
                step();
            end
            if (mw > 15) begin
                fault_now = 1'b1;
                in_halt   = 1'b1;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            push("exec", exec_vec(ir, zf));
            step();
        end
    endtask

    task automatic reset_seq(input outs_t cur);
        rst              = 1'b1;
        processor_enable = 1'b1;
        mem_ack          = 1'b0;
        push("rst_cycle", cur);
        step();
        rst              = 1'b0;
        fault_now        = 1'b0;
        in_halt          = 1'b0;
        processor_enable = 1'b0;
        push("reset_hold", idle_vec(instruction, 3'd0));
        step();
        processor_enable = 1'b1;
        push("reset_go", idle_vec(instruction, 3'd0));
        step();
    endtask

    task automatic halt_and_reset();
        for (int i = 0; i < 3; i++) begin
            mem_ack          = 1'($urandom_range(0, 1));
            processor_enable = 1'($urandom_range(0, 1));
            push("halt", idle_vec(instruction, 3'd5));
            step();
        end
        reset_seq(idle_vec(instruction, 3'd5));
    endtask

    // Reset out of FETCH, then shift 3'b100 into the state register and run the EXEC cycle.
    task automatic scan_test(input logic [7:0] ir, input logic zf);
        logic [2:0] st;
        logic [2:0] bits;
        bits    = 3'b100;
        rst     = 1'b1;
        mem_ack = 1'b0;
        push("rst_mid_fetch", fetch_vec(1'b0));
        step();
        rst         = 1'b0;
        fault_now   = 1'b0;
        instruction = ir;
        ZF          = zf;
        st          = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            scan_enable      = 1'b1;
            scan_in          = bits[i];
            processor_enable = 1'($urandom_range(0, 1));
            mem_ack          = 1'($urandom_range(0, 1));
            push("scan_shift", idle_vec(instruction, st));
            step();
            st = {st[1:0], bits[i]};
        end
        scan_enable      = 1'b0;
        scan_in          = 1'b0;
        processor_enable = 1'b1;
        mem_ack          = 1'b0;
        push("scan_exec", exec_vec(ir, zf));
        step();
    endtask

    initial begin
        logic [7:0] ir;
        int         r;
        int         fw;
        int         mw;
        rst              = 1'b1;
        processor_enable = 1'b0;
        instruction      = 8'h00;
        ZF               = 1'b0;
        mem_ack          = 1'b0;
        scan_enable      = 1'b0;
        scan_in          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push("reset_idle", idle_vec(instruction, 3'd0));
        step();
        push("reset_idle", idle_vec(instruction, 3'd0));
        step();
        processor_enable = 1'b1;
        push("reset_go", idle_vec(instruction, 3'd0));
        step();

        run_instr(8'h05, 1'b0, 2, 2);
        run_instr(8'h25, 1'b0, 1, 0);
        run_instr(8'hF2, 1'b1, 0, 0);
        run_instr(8'hF2, 1'b0, 0, 0);
        run_instr(8'hF5, 1'b0, 0, 0);
        run_instr(8'hFB, 1'b0, 15, 15);
        run_instr(8'hFF, 1'b0, 0, 0);
        halt_and_reset();
        run_instr(8'h10, 1'b0, 16, 0);
        halt_and_reset();
        run_instr(8'h45, 1'b0, 0, 16);
        halt_and_reset();
        scan_test(8'hF0, 1'b0);
        scan_test(8'hE3, 1'b1);

        for (int n = 0; n < 80; n++) begin
            ir = 8'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 19));
            fw = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 19));
            mw = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 3));
            run_instr(ir, 1'($urandom_range(0, 1)), fw, mw);
            if (in_halt) halt_and_reset();
            if ($urandom_range(0, 15) == 0) scan_test(8'($urandom_range(8'hE0, 8'hFE)), 1'($urandom_range(0, 1)));
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
